// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - hazard detection and stall/flush control beside the ID stage
//
// Purpose:
//   Detects hazards that forwarding cannot cover (load-use, ID-stage branch
//   operands, busy mult/div unit) and drives the PC / IF_ID hold, the ID_EX
//   bubble and the IF_ID squash. Also tracks the mult/div busy window.
//
// Optional feature macro: HAZARD_PERF_EN (stall-cycle counter on Stall_Cycles).
//
// Ports:
//   CLK, RST_N                       clock, synchronous active-low reset
//   ID_RS, ID_RT, ID_UsesRT          ID-stage source registers, RT read enable
//   ID_Branch, ID_BranchTaken        ID-stage branch and its resolved outcome
//   ID_MD_Start, ID_MD_Read          ID-stage mult/div start, mfhi/mflo
//   ID_EX_RegWrite/MemtoReg/WriteReg EX-stage destination info
//   EX_MEM_MemtoReg/WriteReg         MEM-stage load destination info
//   PC_Stall, IF_ID_Stall            hold PC and IF/ID
//   ID_EX_Flush, IF_ID_Flush         bubble into ID/EX, squash IF/ID
//   MD_Busy, MD_Done                 mult/div busy level, completion pulse
//   Stall_Cycles                     stalled-cycle count (0 without HAZARD_PERF_EN)
module hazard_stall_unit #(
  parameter int MD_LATENCY = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_UsesRT,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_MD_Start,
  input  logic        ID_MD_Read,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemtoReg,
  input  logic [4:0]  ID_EX_WriteReg,
  input  logic        EX_MEM_MemtoReg,
  input  logic [4:0]  EX_MEM_WriteReg,
  output logic        PC_Stall,
  output logic        IF_ID_Stall,
  output logic        ID_EX_Flush,
  output logic        IF_ID_Flush,
  output logic        MD_Busy,
  output logic        MD_Done,
  output logic [31:0] Stall_Cycles
);

  localparam int CW = $clog2(MD_LATENCY + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MD_RUN = 2'd1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          md_done_q, md_done_d;

  logic lu, br1, br2, mds, stall_raw, stall;

  // $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] d);
    return (r == d) && (d != 5'd0);
  endfunction

  function automatic logic src_match(input logic [4:0] d);
    return reg_match(ID_RS, d) || (ID_UsesRT && reg_match(ID_RT, d));
  endfunction

  always_comb begin
    lu  = ID_EX_MemtoReg & src_match(ID_EX_WriteReg);
    // Branches compare in ID, so any EX producer and a MEM load are too late to forward.
    br1 = ID_Branch & ID_EX_RegWrite & src_match(ID_EX_WriteReg);
    br2 = ID_Branch & EX_MEM_MemtoReg & src_match(EX_MEM_WriteReg);
    mds = MD_Busy & (ID_MD_Start | ID_MD_Read);
    stall_raw = lu | br1 | br2 | mds;
    stall     = stall_raw & RST_N;
  end

  assign PC_Stall    = stall;
  assign IF_ID_Stall = stall;
  assign ID_EX_Flush = stall;
  // A stalled branch is re-evaluated next cycle, so it must not squash yet.
  assign IF_ID_Flush = ID_BranchTaken & ~stall_raw & RST_N;

  assign MD_Busy = (count_q != '0);
  assign MD_Done = md_done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (ID_MD_Start && !stall) begin
          state_d = ST_MD_RUN;
          count_d = CW'(MD_LATENCY);
        end
      end
      ST_MD_RUN: begin
        count_d = count_q - CW'(1);
        if (count_q <= CW'(1)) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    // Done is high during the cycle in which the count moves 1 -> 0.
    md_done_d = (count_d == CW'(1));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      md_done_q <= md_done_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) stall_cycles_q <= 32'd0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign Stall_Cycles = stall_cycles_q;
`else
  assign Stall_Cycles = 32'd0;
`endif

endmodule
